// File: rtl/extensor_pipe_if.sv
// extensor_pipe_if: handshake bundle for the immediate-extension FIFO.
//   in_valid/in_ready/in_data/in_mode : producer side (decode)
//   out_valid/out_ready/out_data      : consumer side (execute)
//   count                             : number of queued entries
// Handshake: a word moves on a rising edge when valid and ready are both 1
// on that side. A producer holds valid and data stable until it sees
// ready=1. The unit keeps out_data stable while out_valid=1 and out_ready=0.
interface extensor_pipe_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [CW-1:0]    count;

    // Environment view: drives the producer inputs and the consumer ready.
    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, count
    );

    // Unit view.
    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, count
    );
endinterface

// File: rtl/extensor_pipe.sv
// extensor_pipe: registered immediate extender with a DEPTH-entry FIFO.
// Ports:
//   clk   - clock, all state on rising edge
//   rst   - asynchronous active-high reset
//   flush - synchronous clear of every queued entry (wins over push/pop)
//   bus   - extensor_pipe_if.slave (in/out handshakes, data, count)
// Modes: 00 sign, 01 zero, 10 upper (LUI), 11 branch (sign-extend, << 2).
module extensor_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int DEPTH = 2
) (
    input logic            clk,
    input logic            rst,
    input logic            flush,
    extensor_pipe_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = OUT_W - IN_W;

    logic [OUT_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    // Cleared by reset and set on the first edge afterwards, so in_ready
    // stays low while rst is high even though count is 0 then.
    logic             ready_q;

    logic             push, pop;
    logic [OUT_W-1:0] sext, ext_d;

    // Extension is purely combinational on the input bus.
    always_comb begin
        sext  = {{EW{bus.in_data[IN_W-1]}}, bus.in_data};
        ext_d = sext;
        case (bus.in_mode)
            2'b00:   ext_d = sext;
            2'b01:   ext_d = {{EW{1'b0}}, bus.in_data};
            2'b10:   ext_d = {bus.in_data, {EW{1'b0}}};
            default: ext_d = {sext[OUT_W-3:0], 2'b00};
        endcase
    end

    // in_ready depends on registered state only; no path from out_ready.
    assign bus.in_ready  = ready_q && (count_q != CW'(DEPTH));
    assign bus.out_valid = (count_q != '0);
    assign bus.out_data  = mem_q[rd_ptr_q];
    assign bus.count     = count_q;

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= 1'b1;
            // Storage is written only on an accepted push, so X on the input
            // bus while in_valid=0 never lands in the FIFO.
            if (push && !flush) mem_q[wr_ptr_q] <= ext_d;
        end
    end
endmodule

// File: tb/tb_extensor_pipe.sv
module tb_extensor_pipe;
    localparam int IN_W  = 16;
    localparam int OUT_W = 32;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;

    extensor_pipe_if #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) bus ();

    extensor_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model state: queue contents plus "has seen an edge since reset".
    logic [OUT_W-1:0] exp_q [$];
    bit               model_en = 1'b0;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic [IN_W-1:0]  data;
        logic [1:0]       mode;
        logic [OUT_W-1:0] exp;
    } vec_t;

    vec_t vecs [6];

    // Extension computed with signed integer arithmetic.
    function automatic logic [OUT_W-1:0] model_ext(input logic [IN_W-1:0] d,
                                                    input logic [1:0] m);
        longint v;
        v = longint'(d);
        if ((m == 2'd0 || m == 2'd3) && d >= 16'h8000) v = v - 65536;
        case (m)
            2'd1:    v = longint'(d);
            2'd2:    v = longint'(d) * 65536;
            2'd3:    v = v * 4;
            default: v = v;
        endcase
        return v[OUT_W-1:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs to the model before the
    // edge, advance the model on the edge. Entered and left at edge+1.
    task automatic cycle(input logic v, input logic [IN_W-1:0] d,
                         input logic [1:0] m, input logic r, input logic f);
        bit exp_rdy, do_push, do_pop;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_mode   = m;
        bus.out_ready = r;
        flush         = f;
        #1;
        exp_rdy = model_en && (exp_q.size() != DEPTH);
        check("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
        check("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
        check("count", 64'(bus.count), 64'(exp_q.size()));
        if (exp_q.size() != 0) check("out_data", 64'(bus.out_data), 64'(exp_q[0]));
        do_push = v && exp_rdy;
        do_pop  = (exp_q.size() != 0) && r;
        @(posedge clk);
        if (f) exp_q.delete();
        else begin
            if (do_pop)  void'(exp_q.pop_front());
            if (do_push) exp_q.push_back(model_ext(d, m));
        end
        if (!rst) model_en = 1'b1;
        #1;
    endtask

    task automatic idle(input logic r);
        cycle(1'b0, '0, 2'd0, r, 1'b0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_mode   = 2'd0;
        bus.out_ready = 1'b0;

        vecs[0] = '{16'hABEA, 2'd0, 32'hFFFFABEA};
        vecs[1] = '{16'hABEA, 2'd1, 32'h0000ABEA};
        vecs[2] = '{16'hABEA, 2'd2, 32'hABEA0000};
        vecs[3] = '{16'hABEA, 2'd3, 32'hFFFEAFA8};
        vecs[4] = '{16'h1234, 2'd0, 32'h00001234};
        vecs[5] = '{16'h1234, 2'd3, 32'h000048D0};

        // Reset state while rst is held.
        #2;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_count", 64'(bus.count), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        #10 rst = 1'b0;   // t=12, away from the edge at 15
        #2;               // t=14 -> enter the cycle task sequence
        idle(1'b0);       // in_ready must still be 0 before the first edge

        // Table: one push per vector, visible one edge later, then popped.
        foreach (vecs[i]) begin
            cycle(1'b1, vecs[i].data, vecs[i].mode, 1'b1, 1'b0);
            check("tbl_valid", 64'(bus.out_valid), 64'd1);
            check("tbl_data", 64'(bus.out_data), 64'(vecs[i].exp));
            idle(1'b1);
        end

        // Back-pressure: three pushes with the consumer stalled.
        cycle(1'b1, 16'h0001, 2'd1, 1'b0, 1'b0);
        cycle(1'b1, 16'h0002, 2'd1, 1'b0, 1'b0);
        cycle(1'b1, 16'h0003, 2'd1, 1'b0, 1'b0);
        check("bp_count_full", 64'(bus.count), 64'd2);
        check("bp_in_ready", 64'(bus.in_ready), 64'd0);
        cycle(1'b1, 16'h0003, 2'd1, 1'b1, 1'b0);
        check("bp_count_after_pop", 64'(bus.count), 64'd1);
        cycle(1'b1, 16'h0003, 2'd1, 1'b0, 1'b0);
        check("bp_count_w2", 64'(bus.count), 64'd2);
        repeat (3) idle(1'b1);

        // Streaming: simultaneous push and pop keeps count at 1.
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 16'(i), 2'd1, 1'b1, 1'b0);
            check("stream_count", 64'(bus.count), 64'd1);
            check("stream_data", 64'(bus.out_data), 64'(i));
        end
        idle(1'b1);

        // Flush with count=2 and simultaneous push/pop.
        cycle(1'b1, 16'h0011, 2'd0, 1'b0, 1'b0);
        cycle(1'b1, 16'h0022, 2'd0, 1'b0, 1'b0);
        cycle(1'b1, 16'h0055, 2'd0, 1'b1, 1'b1);
        check("flush_count", 64'(bus.count), 64'd0);
        check("flush_valid", 64'(bus.out_valid), 64'd0);
        cycle(1'b1, 16'h0077, 2'd1, 1'b0, 1'b0);
        check("flush_next", 64'(bus.out_data), 64'h77);
        idle(1'b1);

        // Asynchronous reset mid-cycle with count=2.
        cycle(1'b1, 16'h0101, 2'd0, 1'b0, 1'b0);
        cycle(1'b1, 16'h0202, 2'd0, 1'b0, 1'b0);
        #3 rst = 1'b1;
        #1;
        check("arst_out_valid", 64'(bus.out_valid), 64'd0);
        check("arst_in_ready", 64'(bus.in_ready), 64'd0);
        check("arst_count", 64'(bus.count), 64'd0);
        exp_q.delete();
        model_en = 1'b0;
        #2 rst = 1'b0;
        #2;               // back to the cycle-task phase (edge-1 region is fine)
        idle(1'b0);
        cycle(1'b1, 16'h8001, 2'd3, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Random traffic against the queue model, with occasional flushes and
        // X on the input bus while in_valid is low.
        for (int i = 0; i < 400; i++) begin
            logic v, r, f;
            logic [IN_W-1:0] d;
            logic [1:0] m;
            v = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            f = ($urandom_range(0, 19) == 0);
            d = 16'($urandom);
            m = 2'($urandom_range(0, 3));
            if (!v && $urandom_range(0, 1) == 1) begin
                d = 'x;
                m = 'x;
            end
            cycle(v, d, m, r, f);
        end
        repeat (3) idle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/extensor_pipe.md
Name: extensor_pipe

Overview:
Parametrised, registered immediate-extension unit for the MIPS datapath. It generalises the fixed 16->32 sign extender to configurable widths and four extension modes. A DEPTH-entry FIFO with valid/ready handshakes sits on both sides, so decode can push immediates while a stalled execute stage drains them later. A synchronous flush discards queued entries on a pipeline squash.

Parameters:
IN_W, 16, input immediate width
OUT_W, 32, output word width; must be >= IN_W+2
DEPTH, 2, FIFO entries; power of two, >= 2

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
flush  input  1  synchronous clear of all queued entries
in_valid  input  1  input word present
in_ready  output  1  unit can accept a word this cycle
in_data  input  IN_W  immediate field
in_mode  input  2  00 sign, 01 zero, 10 upper, 11 branch
out_valid  output  1  head entry valid
out_ready  input  1  consumer takes the head entry this cycle
out_data  output  OUT_W  extended head entry
count  output  clog2(DEPTH+1)  number of queued entries

Behaviour:
- One clock (clk); rst is asynchronous and active-high. While rst=1: count=0, read/write pointers=0, all storage=0, out_valid=0, out_data=0, in_ready=0.
- After rst falls, in_ready=1 from the first clk edge onward.
- Extension is combinational on in_data/in_mode; the result is written into the FIFO.
- Mode 00 (sign): replicate in_data[IN_W-1] into bits OUT_W-1..IN_W.
- Mode 01 (zero): upper OUT_W-IN_W bits are 0.
- Mode 10 (upper, LUI): in_data occupies bits OUT_W-1..OUT_W-IN_W; low bits are 0.
- Mode 11 (branch): sign-extend, then shift left by 2; truncate to OUT_W.
- Push: occurs when in_valid & in_ready.
- Pop: occurs when out_valid & out_ready.
- in_ready = (count != DEPTH). It is registered-state only, with no combinational path from out_ready.
- out_valid = (count != 0). out_data = storage[rd_ptr], which is stable while out_valid=1 and out_ready=0.
- Latency: a word pushed on edge N is visible on out_data/out_valid after edge N. There is no same-cycle bypass.
- Push and pop in the same cycle: both pointers advance and count is unchanged. This is legal at count=DEPTH only if the push was accepted, which it cannot be because in_ready=0 when full. When full, a pop alone frees a slot on the next cycle.
- Pointers wrap modulo DEPTH.
- Empty + out_ready=1: no pop; state is unchanged.
- Full + in_valid=1: word ignored and not stored. The producer holds in_valid/in_data until in_ready=1.
- flush=1 at an edge: count=0 and rd_ptr=wr_ptr=0. Any simultaneous push or pop is discarded, and flush wins. Storage contents need not be cleared.
- out_data after flush is don't-care; the bench checks it only when out_valid=1.
- rst asserted mid-operation: immediate return to the reset state, regardless of clk and in-flight handshakes.
- X on in_mode or in_data when in_valid=0 must not corrupt state.

Test Plan:
1. Reset then single pushes, one per mode, of in_data=16'hABEA, each popped immediately -> out_data = 32'hFFFFABEA, 32'h0000ABEA, 32'hABEA0000, 32'hFFFEAFA8 respectively, each one cycle after acceptance.
2. Positive value 16'h1234 in mode 00 -> 32'h00001234. In mode 11 -> 32'h000048D0.
3. Back-pressure: out_ready=0, push 3 words -> first two accepted, count=2, in_ready=0, third held. Then set out_ready=1 for one cycle -> count=1, then third accepted. Order out: w0, w1, w2.
4. Streaming with in_valid=out_ready=1 for 10 cycles, incrementing data 0..9 in mode 01 -> out_data 0..9 in order, count stays 1, pointers wrap, no drop or duplicate.
5. Flush with count=2 while in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, the pushed word is absent, and the next push emerges first.
6. Assert rst asynchronously mid-cycle with count=2 -> out_valid, in_ready and count go to 0 immediately without a clk edge. After release, normal operation resumes with an empty FIFO.
